csync_separator: RTL and testbench
==================================

Name: csync_separator

Overview:
- Decoder counterpart to the SCART composite-sync generator: recovers line sync, field sync and field parity from a composite sync input (e.g. AIV csync).
- Runs on the 6x pixel clock domain.
- Provides frame/line timing to downstream capture logic.
- Classifies each low-going csync pulse by width and tracks lock.

Parameters:
- CNT_W, 13, width of pulse-width and edge-interval counters (saturating).
- SHORT_MAX, 285, max low width (cycles) classed as equalising pulse.
- NORMAL_MAX, 760, max low width classed as line sync; widths above SHORT_MAX up to this value are line sync.
- BROAD_MIN, 1500, min low width classed as broad (field) pulse; widths between NORMAL_MAX and BROAD_MIN are invalid.
- HALF_LINE_MAX, 3900, falling-edge interval at or below this value counts as a half line.
- TIMEOUT_CYCLES, 8000, no falling edge for this many cycles drops lock.
- BROAD_COUNT, 3, consecutive broad pulses required to assert field sync.
- MAX_LINES, 320, line_count above this value drops lock.

Ports:
- sysClk, input, 1, system clock (6x pixel clock).
- reset, input, 1, asynchronous active-high reset.
- csync_in, input, 1, raw composite sync (active low), asynchronous to sysClk.
- hsync_pulse, output, 1, one-cycle pulse per valid line sync.
- vsync_pulse, output, 1, one-cycle pulse at field sync.
- field, output, 1, field parity of the current field (1 = field starting on a half line).
- line_count, output, 10, line-sync count since last vsync_pulse.
- locked, output, 1, timing is valid.
- pulse_width, output, CNT_W, width of the last classified low pulse.

Behaviour:
- Reset, async: all outputs 0, counters 0, state SEARCH.
- Input path: csync_in passes through a 2-FF synchroniser (cs_s). Edge detection is done on cs_s against its previous value.
- Width counter: cleared on a cs_s falling edge, then increments while cs_s is low, saturating at all-ones.
- Interval counter: cleared on each falling edge, increments otherwise, saturating. Its value at a falling edge is latched as last_interval.
- Classification happens on the cs_s rising edge. Outputs update 1 cycle later, and pulse_width loads at the same time.
  - SHORT: width <= SHORT_MAX.
  - NORMAL: SHORT_MAX < width <= NORMAL_MAX.
  - BROAD: width >= BROAD_MIN.
  - INVALID: anything else. INVALID pulses are ignored and reset the broad run counter.
- NORMAL pulse:
  - hsync_pulse asserts for 1 cycle.
  - line_count increments and saturates at 1023.
  - broad run counter clears.
- SHORT pulse: broad run counter clears. No output pulse.
- BROAD pulse: broad run counter increments and saturates.
  - When the counter reaches BROAD_COUNT, vsync_pulse asserts for 1 cycle.
  - line_count clears to 0 on that same cycle.
  - field loads (interval_at_first_broad <= HALF_LINE_MAX).
  - Further broad pulses in the same run do not re-pulse.
- interval_at_first_broad is the last_interval captured at the falling edge of the first broad pulse in a run.
- State machine:
  - SEARCH -> LOCKED on vsync_pulse.
  - LOCKED -> SEARCH if the interval counter reaches TIMEOUT_CYCLES, or if line_count > MAX_LINES.
  - locked = (state == LOCKED). The drop takes effect the cycle after the condition.
- hsync_pulse and vsync_pulse are generated in both states. They never assert in the same cycle, because classification is exclusive.
- Boundary conditions:
  - csync stuck low: the width counter saturates, the pulse is never classified, and lock drops on timeout.
  - csync stuck high: lock drops on timeout.
  - A reset asserted mid-pulse discards that pulse. The first falling edge after release starts fresh.
  - A rising edge with no preceding falling edge since reset is not classified.
- Total latency from csync_in rising edge to an output pulse: 4 cycles (2 sync + 1 edge + 1 register).

Optional Feature:
- Macro: CSYNC_GLITCH_FILTER_EN.
- Defined: a stability filter sits after the synchroniser. cs_s changes only after the synchronised input holds a new value for 8 consecutive cycles. Pulses shorter than 8 cycles are discarded entirely. Latency rises to 12 cycles, and measured widths are unchanged apart from a constant offset that cancels, since both edges are delayed equally.
- Undefined: no filter, 4-cycle latency, and glitches of 1 cycle or more are seen as pulses (classified SHORT).

Test Plan:
- Line syncs: 381-cycle low pulses every 5184 cycles -> hsync_pulse once per line at rising edge +4, pulse_width=381, locked stays 0.
- Field sequence: normal lines, then five 190-cycle equalising pulses at 2592 spacing, then five 2211-cycle broad pulses -> one vsync_pulse on the 3rd broad pulse, line_count=0, field=1, locked=1 next cycle.
- Field parity: same sequence but the first broad pulse follows a 5184-cycle interval -> field=0.
- Loss of lock: while locked, hold csync_in high for 8001 cycles -> locked falls to 0, and no hsync_pulse/vsync_pulse is emitted.
- Invalid width: a 1000-cycle low pulse between two broad pulses -> no output pulses, broad run restarts, and vsync only after 3 further broad pulses.
- Reset mid-pulse: assert reset during a 2211-cycle broad pulse -> all outputs 0 immediately, and the partial pulse is never classified after release. With CSYNC_GLITCH_FILTER_EN, a 5-cycle low glitch -> no width update and no pulses.

Source files
------------

// File: rtl/csync_separator.sv
// csync_separator: recovers line sync, field sync and field parity from an
// active-low composite sync input, running on the 6x pixel clock.
// Each low pulse is measured and classified as equalising (SHORT), line
// sync (NORMAL), field/broad (BROAD) or INVALID. A run of broad pulses
// produces field sync, and a small FSM tracks lock.
// Optional build macro: CSYNC_GLITCH_FILTER_EN adds an 8-cycle stability
// filter after the synchroniser, so pulses shorter than 8 cycles are dropped.
module csync_separator #(
  parameter int CNT_W          = 13,
  parameter int SHORT_MAX      = 285,
  parameter int NORMAL_MAX     = 760,
  parameter int BROAD_MIN      = 1500,
  parameter int HALF_LINE_MAX  = 3900,
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int BROAD_COUNT    = 3,
  parameter int MAX_LINES      = 320
) (
  input  logic             sysClk,
  input  logic             reset,
  input  logic             csync_in,
  output logic             hsync_pulse,
  output logic             vsync_pulse,
  output logic             field,
  output logic [9:0]       line_count,
  output logic             locked,
  output logic [CNT_W-1:0] pulse_width
);

  localparam int RUN_W = $clog2(BROAD_COUNT + 1);

  // Thresholds cast to the counter width so every compare is width-matched.
  localparam logic [CNT_W-1:0] SHORT_LIM   = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] NORMAL_LIM  = CNT_W'(NORMAL_MAX);
  localparam logic [CNT_W-1:0] BROAD_LIM   = CNT_W'(BROAD_MIN);
  localparam logic [CNT_W-1:0] HALF_LIM    = CNT_W'(HALF_LINE_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [9:0]       LINES_LIM   = 10'(MAX_LINES);
  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(BROAD_COUNT);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(BROAD_COUNT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;
  typedef enum logic [1:0] {PC_SHORT, PC_NORMAL, PC_BROAD, PC_INVALID} pulse_class_t;

  state_t       state, next_state;
  pulse_class_t pclass;

  logic             cs_meta, cs_sync, cs_s, cs_prev;
  logic             fall, rise, rise_q, armed, classify;
  logic [CNT_W-1:0] width_cnt, interval_cnt, last_interval;
  logic [CNT_W-1:0] first_broad_interval, first_iv_now;
  logic [RUN_W-1:0] broad_run;

  // Two-flop synchroniser for the asynchronous csync input.
  // NOTE: the synchroniser resets low so that a line held low through reset
  // produces no falling edge after release; the partial pulse is never seen.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      cs_meta <= 1'b0;
      cs_sync <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      cs_meta <= csync_in;
      cs_sync <= cs_meta;
    end
  end

`ifdef CSYNC_GLITCH_FILTER_EN
  logic [2:0] stable_cnt;

  // Stability filter: cs_s follows cs_sync only after 8 identical cycles.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      cs_s       <= 1'b0;
      stable_cnt <= 3'd0;
    end else if (cs_sync == cs_s) begin
      stable_cnt <= 3'd0;
    end else if (stable_cnt == 3'd7) begin
      cs_s       <= cs_sync;
      stable_cnt <= 3'd0;
    end else begin
      stable_cnt <= stable_cnt + 3'd1;
    end
  end
`else
  assign cs_s = cs_sync;
`endif

  assign fall     = cs_prev & ~cs_s;
  assign rise     = ~cs_prev & cs_s;
  assign classify = rise_q & armed;

  // Edge stage: previous cs_s value and the registered rising-edge strobe.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      cs_prev <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cs_prev <= cs_s;
      rise_q  <= rise;
    end
  end

  // Width and interval counters, both saturating. The fall cycle is itself
  // the first low cycle, so the width counter restarts at one.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      width_cnt     <= '0;
      interval_cnt  <= '0;
      last_interval <= '0;
      armed         <= 1'b0;
    end else begin
      if (fall) begin
        width_cnt <= CNT_W'(1);
      end else if (!cs_s && width_cnt != '1) begin
        width_cnt <= width_cnt + CNT_W'(1);
      end

      if (fall) begin
        interval_cnt  <= '0;
        last_interval <= interval_cnt;
      end else if (interval_cnt != '1) begin
        interval_cnt <= interval_cnt + CNT_W'(1);
      end

      // A rising edge is only meaningful if its falling edge was seen.
      if (fall) begin
        armed <= 1'b1;
      end else if (rise_q) begin
        armed <= 1'b0;
      end
    end
  end

  // Width classification of the pulse that just ended.
  always_comb begin
    // NOTE: default first so every path assigns pclass and no latch forms.
    pclass = PC_INVALID;
    if (width_cnt <= SHORT_LIM) begin
      pclass = PC_SHORT;
    end else if (width_cnt <= NORMAL_LIM) begin
      pclass = PC_NORMAL;
    end else if (width_cnt >= BROAD_LIM) begin
      pclass = PC_BROAD;
    end
  end

  // When the first broad pulse of a run is also the last one needed, its
  // interval has not been captured yet, so use it directly.
  assign first_iv_now = (broad_run == '0) ? last_interval : first_broad_interval;

  // Output events, line counting and the broad-pulse run.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      hsync_pulse          <= 1'b0;
      vsync_pulse          <= 1'b0;
      field                <= 1'b0;
      line_count           <= '0;
      pulse_width          <= '0;
      broad_run            <= '0;
      first_broad_interval <= '0;
    end else begin
      hsync_pulse <= 1'b0;
      vsync_pulse <= 1'b0;
      if (classify) begin
        pulse_width <= width_cnt;
        case (pclass)
          PC_NORMAL: begin
            hsync_pulse <= 1'b1;
            broad_run   <= '0;
            if (line_count != '1) begin
              line_count <= line_count + 10'd1;
            end
          end
          PC_BROAD: begin
            if (broad_run == '0) begin
              first_broad_interval <= last_interval;
            end
            if (broad_run != RUN_FULL) begin
              broad_run <= broad_run + RUN_W'(1);
              if (broad_run == RUN_LAST) begin
                vsync_pulse <= 1'b1;
                line_count  <= '0;
                field       <= (first_iv_now <= HALF_LIM);
              end
            end
          end
          default: begin
            broad_run <= '0;
          end
        endcase
      end
    end
  end

  // Lock state register.
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= next_state;
    end
  end

  // Lock next-state: gain on field sync, lose on timeout or too many lines.
  always_comb begin
    next_state = state;
    case (state)
      SEARCH: begin
        if (vsync_pulse) begin
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (interval_cnt >= TIMEOUT_LIM || line_count > LINES_LIM) begin
          next_state = SEARCH;
        end
      end
      default: next_state = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_csync_separator.sv
// Scoreboard bench for csync_separator: a pulse-level reference model turns
// each driven low pulse into the expected hsync/vsync event, and a monitor
// compares every event the design emits against the queue.
module tb_csync_separator;

`ifdef CSYNC_GLITCH_FILTER_EN
  localparam int LAT      = 12;
  localparam int MIN_SEEN = 8;
`else
  localparam int LAT      = 4;
  localparam int MIN_SEEN = 1;
`endif
  localparam int TIMEOUT  = 8000;
  localparam int HALF_MAX = 3900;

  logic        sysClk = 1'b0;
  logic        reset;
  logic        csync_in;
  logic        hsync_pulse, vsync_pulse, field, locked;
  logic [9:0]  line_count;
  logic [12:0] pulse_width;

  csync_separator dut (
    .sysClk      (sysClk),
    .reset       (reset),
    .csync_in    (csync_in),
    .hsync_pulse (hsync_pulse),
    .vsync_pulse (vsync_pulse),
    .field       (field),
    .line_count  (line_count),
    .locked      (locked),
    .pulse_width (pulse_width)
  );

  always #5 sysClk = ~sysClk;

  longint cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit     is_v;
    longint at;
    int     width;
    int     line;
    bit     fld;
    bit     lck;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state, expressed per pulse rather than per cycle.
  bit     m_armed, m_locked, m_field;
  int     m_run, m_line, m_width, m_first_iv, m_last_iv;
  longint m_prev_fall;

  function automatic int class_of(input int w);
    if (w <= 285) return 0;        // equalising
    if (w <= 760) return 1;        // line sync
    if (w >= 1500) return 2;       // broad
    return 3;                      // invalid
  endfunction

  task automatic model_reset();
    m_armed = 0; m_locked = 0; m_field = 0;
    m_run = 0; m_line = 0; m_width = 0; m_first_iv = 0; m_last_iv = 0;
    m_prev_fall = cyc;
  endtask

  task automatic model_fall(input longint f);
    longint d;
    d = f - m_prev_fall - 1;
    m_last_iv = (d > 8191) ? 8191 : int'(d);
    if (m_locked && m_last_iv >= TIMEOUT) m_locked = 0;
    m_prev_fall = f;
    m_armed = 1;
  endtask

  task automatic model_rise(input int low, input longint r);
    exp_t e;
    if (!m_armed) return;
    m_armed = 0;
    m_width = low;
    case (class_of(low))
      1: begin
        if (m_line < 1023) m_line++;
        m_run = 0;
        e = '{0, r + LAT, low, m_line, m_field, m_locked};
        exp_q.push_back(e);
        if (m_line > 320) m_locked = 0;
      end
      2: begin
        if (m_run == 0) m_first_iv = m_last_iv;
        if (m_run < 3) begin
          m_run++;
          if (m_run == 3) begin
            m_line  = 0;
            m_field = (m_first_iv <= HALF_MAX);
            e = '{1, r + LAT, low, 0, m_field, m_locked};
            exp_q.push_back(e);
            m_locked = 1;
          end
        end
      end
      default: m_run = 0;
    endcase
  endtask

  // Drive one low pulse followed by a high gap; called just after a negedge.
  task automatic send_pulse(input int low, input int high);
    csync_in = 1'b0;
    if (low >= MIN_SEEN) model_fall(cyc);
    repeat (low) @(negedge sysClk);
    csync_in = 1'b1;
    if (low >= MIN_SEEN) model_rise(low, cyc);
    repeat (high) @(negedge sysClk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hsync"}, hsync_pulse, 0);
    check({tag, "_vsync"}, vsync_pulse, 0);
    check({tag, "_field"}, field, 0);
    check({tag, "_line"}, line_count, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_width"}, pulse_width, 0);
  endtask

  // Monitor: every emitted event is matched against the next expectation.
  always @(negedge sysClk) begin
    if (hsync_pulse || vsync_pulse) begin
      exp_t e;
      check("pulse_exclusive", hsync_pulse & vsync_pulse, 0);
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_kind", vsync_pulse, e.is_v);
        check("event_cycle", cyc, e.at);
        check("event_width", pulse_width, e.width);
        check("event_line", line_count, e.line);
        check("event_field", field, e.fld);
        check("event_locked", locked, e.lck);
      end
    end
  end

  // Watchdog keeps the run bounded even if the stimulus stalls.
  initial begin
    #(99000 * 10);
    $display("FAIL watchdog: cycle %0d reached limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, k;
    reset = 1'b1;
    csync_in = 1'b1;
    repeat (3) @(negedge sysClk);
    check_idle_outputs("reset");
    reset = 1'b0;
    model_reset();
    repeat (20) @(negedge sysClk);

    // Plain line syncs while unlocked.
    repeat (2) send_pulse(381, 4803);

    // Random pulse mix including the classification boundaries.
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: w = $urandom_range(20, 285);
        1: w = 285;
        2: w = 286;
        3: w = $urandom_range(300, 760);
        4: w = 760;
        5: w = 761;
        6: w = $urandom_range(800, 1400);
        7: w = 1499;
        8: w = 1500;
        default: w = $urandom_range(1500, 1800);
      endcase
      h = $urandom_range(200, 900);
      send_pulse(w, h);
    end

    // Field starting on a half line: equalising then broad pulses.
    repeat (5) send_pulse(190, 2402);
    repeat (4) send_pulse(2211, 381);
    check("locked_after_field", locked, m_locked);

    // Field starting on a whole line: first broad after a full line interval.
    send_pulse(381, 4803);
    repeat (3) send_pulse(2211, 381);

    // Invalid width splits a broad run.
    send_pulse(2211, 200);
    send_pulse(1000, 200);
    repeat (3) send_pulse(2211, 200);
    check("locked_before_idle", locked, m_locked);

    // Line held high long enough to time out.
    repeat (8100) @(negedge sysClk);
    if (m_locked && (cyc - m_prev_fall - 1) >= TIMEOUT) m_locked = 0;
    check("locked_after_timeout", locked, m_locked);

    // Short glitch: a SHORT pulse without filtering, invisible with it.
    send_pulse(3, 400);
    check("glitch_width", pulse_width, m_width);

    // Reset asserted in the middle of a broad pulse.
    csync_in = 1'b0;
    model_fall(cyc);
    repeat (1000) @(negedge sysClk);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midreset");
    @(negedge sysClk);
    reset = 1'b0;
    model_reset();
    repeat (500) @(negedge sysClk);
    csync_in = 1'b1;
    model_rise(1711, cyc);
    repeat (400) @(negedge sysClk);
    check("midreset_width", pulse_width, m_width);
    send_pulse(381, 1000);

    repeat (50) @(negedge sysClk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
